// File: rtl/reg_fifo_pkg.sv
// Shared definitions for the register FIFO: the per-cycle operation encoding
// and the decode from the accepted handshakes.
package reg_fifo_pkg;

  // Encoded as {pop, push} so the decode is a plain concatenation.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e decode_op(input logic do_push, input logic do_pop);
    return fifo_op_e'({do_pop, do_push});
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Circular pointer register: async active-low reset, synchronous clear,
// increment enable. Wraps modulo 2**ADDR_W through natural overflow.
module fifo_ptr #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/reg_fifo.sv
// Register-based show-ahead FIFO with synchronous flush. The oldest entry is
// always on data_out; status outputs are decoded from the occupancy counter.
module reg_fifo
  import reg_fifo_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int DEEP   = 8,
  localparam int ADDR_W = $clog2(DEEP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEEP);

  logic [WIDTH-1:0]  mem [DEEP];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              do_push;
  logic              do_pop;
  fifo_op_e          op;

  // A push into a full queue is only taken when a pop frees the head slot
  // in the same cycle; a pop on an empty queue is ignored.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign op      = decode_op(do_push, do_pop);

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (do_push),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (do_pop),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (op)
        OP_PUSH: cnt <= cnt + (ADDR_W+1)'(1);
        OP_POP:  cnt <= cnt - (ADDR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is deliberately not reset; data_out is meaningless while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= data_in;
    end
  end

  assign data_out = mem[rd_ptr];
  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_FULL);
  assign count    = cnt;

`ifndef SYNTHESIS
  a_cnt_bound: assert property (@(posedge clk) disable iff (!reset)
    cnt <= CNT_FULL);
  a_ptr_cnt: assert property (@(posedge clk) disable iff (!reset)
    ADDR_W'(wr_ptr - rd_ptr) == cnt[ADDR_W-1:0]);
  a_full_empty: assert property (@(posedge clk) disable iff (!reset)
    !(full && empty));
`endif

endmodule

// File: tb/tb_reg_fifo.sv
// Directed scoreboard bench for reg_fifo: drivers push expected words into a
// queue, a negedge monitor pops and compares whenever an accepted pop is due.
module tb_reg_fifo;

  localparam int WIDTH = 32;
  localparam int DEEP  = 8;
  localparam int AW    = $clog2(DEEP);

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic [AW:0]      count;

  logic [WIDTH-1:0] exp_q[$];
  int               m_cnt   = 0;
  logic             pop_chk = 1'b0;
  int               errors  = 0;
  int               checks  = 0;

  reg_fifo #(.WIDTH(WIDTH), .DEEP(DEEP)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_status(input string name);
    check({name, ".count"}, WIDTH'(count), WIDTH'(m_cnt));
    check({name, ".empty"}, WIDTH'(empty), WIDTH'(m_cnt == 0));
    check({name, ".full"},  WIDTH'(full),  WIDTH'(m_cnt == DEEP));
  endtask

  // driver: inputs change 1 time unit after posedge; model tracks acceptance
  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d);
    logic acc_pop, acc_push;
    push    = p;
    pop     = q;
    data_in = d;
    flush   = 1'b0;
    acc_pop  = q && (m_cnt > 0);
    acc_push = p && ((m_cnt < DEEP) || acc_pop);
    pop_chk  = acc_pop;
    if (acc_push) exp_q.push_back(d);
    m_cnt = m_cnt + int'(acc_push) - int'(acc_pop);
    @(posedge clk); #1;
    push    = 1'b0;
    pop     = 1'b0;
    pop_chk = 1'b0;
  endtask

  task automatic do_flush(input logic p, input logic [WIDTH-1:0] d);
    flush   = 1'b1;
    push    = p;
    data_in = d;
    pop_chk = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    push  = 1'b0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  // monitor: head word must match the scoreboard whenever a pop is accepted
  always @(negedge clk) begin
    if (pop_chk) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: pop with empty scoreboard");
      end else begin
        check("pop_data", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check_status("reset");

    step(1'b0, 1'b1, '0);
    check_status("pop_empty");

    // order
    step(1'b1, 1'b0, 32'h11);
    step(1'b1, 1'b0, 32'h22);
    step(1'b1, 1'b0, 32'h33);
    check_status("order_fill");
    check("order_head", data_out, 32'h11);
    repeat (3) step(1'b0, 1'b1, '0);
    check_status("order_drain");

    // full, dropped ninth push
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'hA0 + i);
    check_status("full_fill");
    step(1'b1, 1'b0, 32'hFF);
    check_status("full_drop");
    check("full_drop_head", data_out, 32'hA0);
    repeat (8) step(1'b0, 1'b1, '0);
    check_status("full_drain");

    // push+pop while full
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'hA0 + i);
    step(1'b1, 1'b1, 32'hB0);
    check_status("full_pp");
    check("full_pp_head", data_out, 32'hA1);
    repeat (8) step(1'b0, 1'b1, '0);
    check_status("full_pp_drain");

    // push+pop while empty: no bypass, word visible next cycle
    step(1'b1, 1'b1, 32'hC0);
    check_status("empty_pp");
    check("empty_pp_head", data_out, 32'hC0);
    step(1'b0, 1'b1, '0);
    check_status("empty_pp_drain");

    // wrap-around at depth 3
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h40 + i);
    for (int i = 3; i < 23; i++) step(1'b1, 1'b1, 32'h40 + i);
    check_status("wrap_mid");
    repeat (3) step(1'b0, 1'b1, '0);
    check_status("wrap_drain");

    // flush beats push
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'hD0 + i);
    check_status("flush_pre");
    do_flush(1'b1, 32'hEE);
    check_status("flush_post");
    step(1'b1, 1'b0, 32'h77);
    check("flush_after_head", data_out, 32'h77);
    step(1'b0, 1'b1, '0);

    // asynchronous reset mid-cycle
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'hE0 + i);
    check_status("areset_pre");
    #2 reset = 1'b0;
    #1;
    m_cnt = 0;
    exp_q.delete();
    check_status("areset_now");
    @(posedge clk); #1 reset = 1'b1;
    check_status("areset_post");

    repeat (2) @(posedge clk);
    check("scoreboard_left", WIDTH'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
